// File: rtl/execute_writeback_stage_if.sv
// rtl/execute_writeback_stage_if.sv - data-cache request/response bundle of the execute-writeback stage
//
// Signals:
//   dcache_addr  word-aligned request address
//   dcache_we    byte write mask (store)
//   dcache_re    load request
//   dcache_din   store data, already shifted to the addressed byte lanes
//   dcache_dout  load data, valid in the writeback cycle of the load
// Modports: master = the pipeline stage, slave = the data cache.
interface execute_writeback_stage_if;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;

    modport master (output dcache_addr, dcache_we, dcache_re, dcache_din, input dcache_dout);
    modport slave  (input dcache_addr, dcache_we, dcache_re, dcache_din, output dcache_dout);
endinterface

// File: rtl/execute_writeback_stage.sv
// rtl/execute_writeback_stage.sv - RV32I execute + writeback stage (ALU, branch, dcache request, writeback slot, tohost CSR)
//
// Ports:
//   clk, reset (asynchronous, active-low), stall (freezes every register)
//   pc, ra, rb, rs1, rs2_shamt, rd, imm            decoded operands of the execute instruction
//   alu_op, add_rshift_type, shift_imm, a_sel, b_sel, funct3, branch, jump,
//   reg_we, mem_we, mem_rr, csr_write, csr_imm     decoded control
//   pc_select, alu_result, bubble                  redirect to the front end
//   dmem (execute_writeback_stage_if.master)       data-cache request / load data
//   wb_we, wb_rd, wb_data                          register-file write port (also the forwarding source)
//   csr                                            tohost CSR
// Optional: define PERF_COUNTERS_EN to add cycle/instret counters and a csr_addr input.
module execute_writeback_stage #(
    parameter logic [11:0] CSR_ADDR     = 12'h51E,
    parameter int          RESET_PC_LSB = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2_shamt,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic [3:0]  alu_op,
    input  logic        add_rshift_type,
    input  logic        shift_imm,
    input  logic        a_sel,
    input  logic        b_sel,
    input  logic [2:0]  funct3,
    input  logic        branch,
    input  logic        jump,
    input  logic        reg_we,
    input  logic        mem_we,
    input  logic        mem_rr,
    input  logic        csr_write,
    input  logic        csr_imm,
`ifdef PERF_COUNTERS_EN
    input  logic [11:0] csr_addr,
`endif
    output logic        pc_select,
    output logic [31:0] alu_result,
    output logic        bubble,
    execute_writeback_stage_if.master dmem,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] csr
);
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SLL   = 4'd1;
    localparam logic [3:0] ALU_SLT   = 4'd2;
    localparam logic [3:0] ALU_SLTU  = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_OR    = 4'd6;
    localparam logic [3:0] ALU_AND   = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd8;

    // Value forced into bit 0 of a jalr target.
    localparam logic JALR_LSB = 1'(RESET_PC_LSB);

    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_raw;
    logic [4:0]  shamt;
    logic        cond_true;
    logic [1:0]  byte_off;
    logic [31:0] csr_rdata;
    logic        csr_hit;

    // Writeback slot
    logic        wb_mem_rr;
    logic [2:0]  wb_funct3;
    logic [1:0]  wb_off;
    logic [31:0] wb_result;
    logic [31:0] ld_shift;

    // Bypass from the writeback slot; wb_data already carries aligned load data.
    assign fwd_a = (wb_we && wb_rd != 5'd0 && wb_rd == rs1)       ? wb_data : ra;
    assign fwd_b = (wb_we && wb_rd != 5'd0 && wb_rd == rs2_shamt) ? wb_data : rb;
    assign op_a  = a_sel ? pc  : fwd_a;
    assign op_b  = b_sel ? imm : fwd_b;
    assign shamt = shift_imm ? rs2_shamt : op_b[4:0];

    always_comb begin
        alu_raw = 32'd0;
        case (alu_op)
            ALU_ADD:   alu_raw = add_rshift_type ? op_a - op_b : op_a + op_b;
            ALU_SLL:   alu_raw = op_a << shamt;
            ALU_SLT:   alu_raw = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_raw = {31'd0, op_a < op_b};
            ALU_XOR:   alu_raw = op_a ^ op_b;
            ALU_SRL:   alu_raw = add_rshift_type ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
            ALU_OR:    alu_raw = op_a | op_b;
            ALU_AND:   alu_raw = op_a & op_b;
            ALU_PASSB: alu_raw = op_b;
            default:   alu_raw = 32'd0;
        endcase
    end

    // jal computes pc+imm (a_sel=1); jalr uses the register operand and drops bit 0.
    assign alu_result = (jump && !a_sel) ? {alu_raw[31:1], JALR_LSB} : alu_raw;

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            3'b000:  cond_true = fwd_a == fwd_b;
            3'b001:  cond_true = fwd_a != fwd_b;
            3'b100:  cond_true = $signed(fwd_a) <  $signed(fwd_b);
            3'b101:  cond_true = $signed(fwd_a) >= $signed(fwd_b);
            3'b110:  cond_true = fwd_a <  fwd_b;
            3'b111:  cond_true = fwd_a >= fwd_b;
            default: cond_true = 1'b0;
        endcase
    end

    // Held while stalled because the upstream inputs are held; consumed on the first free edge.
    assign pc_select = reset && (jump || (branch && cond_true));
    assign bubble    = pc_select;

    assign byte_off         = alu_result[1:0];
    assign dmem.dcache_addr = {alu_result[31:2], 2'b00};
    assign dmem.dcache_re   = mem_rr;

    always_comb begin
        dmem.dcache_we  = 4'b0000;
        dmem.dcache_din = fwd_b;
        case (funct3[1:0])
            2'b00: begin
                dmem.dcache_we  = 4'b0001 << byte_off;
                dmem.dcache_din = fwd_b << {byte_off, 3'b000};
            end
            2'b01: begin
                dmem.dcache_we  = 4'b0011 << {byte_off[1], 1'b0};
                dmem.dcache_din = fwd_b << {byte_off[1], 4'b0000};
            end
            default: dmem.dcache_we = 4'b1111;
        endcase
        if (!mem_we) dmem.dcache_we = 4'b0000;
    end

`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_cnt, instret_cnt;
    logic        squash_q;   // the instruction now in execute was fetched down a redirected path

    assign csr_hit   = csr_addr == CSR_ADDR;
    assign csr_rdata = (csr_addr == 12'hC00) ? cycle_cnt :
                       (csr_addr == 12'hC02) ? instret_cnt : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
            squash_q    <= 1'b0;
        end else if (!stall) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (!squash_q) instret_cnt <= instret_cnt + 32'd1;
            squash_q <= pc_select;
        end
    end
`else
    // No address port: every CSR write targets the tohost register, reads return 0.
    logic [11:0] csr_sel;
    assign csr_sel   = CSR_ADDR;
    assign csr_hit   = csr_sel == CSR_ADDR;
    assign csr_rdata = 32'd0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_result <= 32'd0;
            wb_mem_rr <= 1'b0;
            wb_funct3 <= 3'd0;
            wb_off    <= 2'd0;
            csr       <= 32'd0;
        end else if (!stall) begin
            wb_we     <= reg_we && rd != 5'd0;
            wb_rd     <= rd;
            wb_result <= jump ? pc + 32'd4 : (csr_write ? csr_rdata : alu_result);
            wb_mem_rr <= mem_rr;
            wb_funct3 <= funct3;
            wb_off    <= byte_off;
            if (csr_write && csr_hit) csr <= csr_imm ? {27'd0, rs1} : fwd_a;
        end
    end

    assign ld_shift = dmem.dcache_dout >> {wb_off, 3'b000};

    always_comb begin
        wb_data = wb_result;
        if (wb_mem_rr) begin
            case (wb_funct3)
                3'b000:  wb_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
                3'b001:  wb_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
                3'b100:  wb_data = {24'd0, ld_shift[7:0]};
                3'b101:  wb_data = {16'd0, ld_shift[15:0]};
                default: wb_data = ld_shift;
            endcase
        end
    end
endmodule

// File: doc/execute_writeback_stage.md
Name: execute_writeback_stage

Overview:
- Pipeline stage directly downstream of the decode-read stage in the 3-stage RV32I core.
- Consumes decoded control, register operands, immediate and PC for one instruction per cycle.
- Performs ALU and branch resolution, issues the dcache request, and redirects the PC.
- Registers results into an internal writeback slot that drives the register-file write port, load alignment, forwarding and the tohost CSR.

Parameters:
- CSR_ADDR, 12'h51E, CSR address written by csrw/csrwi.
- RESET_PC_LSB, 0, reserved; must remain 0.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  memory stall; freezes every internal register
- pc  in  32  PC of the execute-stage instruction
- ra, rb  in  32  register-file read data
- rs1, rs2_shamt, rd  in  5  register indices
- imm  in  32  generated immediate
- alu_op  in  4  ALU operation, `ALU_*` encodings of const.vh
- add_rshift_type  in  1  sub/sra select
- shift_imm  in  1  shamt taken from rs2_shamt
- a_sel, b_sel  in  1  A: 0=reg 1=pc; B: 0=reg 1=imm
- funct3  in  3  branch condition / load-store size
- branch, jump  in  1  conditional branch, jal/jalr
- reg_we, mem_we, mem_rr  in  1  write-back enable, store, load
- csr_write, csr_imm  in  1  CSR write, zimm form (rs1 field used as data)
- pc_select  out  1  redirect PC to alu_result
- alu_result  out  32  ALU output (branch/jump target)
- bubble  out  1  squash upstream instruction
- dcache_addr  out  32  word-aligned address
- dcache_we  out  4  byte write mask
- dcache_re  out  1  load request
- dcache_din  out  32  lane-shifted store data
- dcache_dout  in  32  load data, valid in writeback cycle
- wb_we  out  1  register-file write enable
- wb_rd  out  5  write address
- wb_data  out  32  write data
- csr  out  32  tohost CSR value

Behaviour:
- Forwarding: if wb_we and wb_rd!=0 and wb_rd==rs1, operand A uses wb_data; rs2 is handled likewise. Forwarded wb_data includes the aligned load result, so there are no load-use stalls.
- ALU: add/sub, sll, slt, sltu, xor, srl/sra, or, and, pass-B (lui).
  - Shift amount = shift_imm ? rs2_shamt : B[4:0].
  - jalr clears alu_result[0].
- Branch: compare forwarded rs1/rs2 per funct3 (beq, bne, blt, bge, bltu, bgeu).
  - pc_select = jump | (branch & cond_true).
  - bubble = pc_select.
  - Both are combinational, zero latency, and forced 0 while reset is asserted.
- Memory request (combinational):
  - dcache_addr = {alu_result[31:2],2'b00}.
  - dcache_re = mem_rr.
  - Store mask: sb 4'b0001<<addr[1:0]; sh 4'b0011<<{addr[1],1'b0}; sw 4'b1111.
  - dcache_din = store data shifted to the addressed lane.
  - While stall=1, dcache outputs stay stable and the instruction is not retired.
- Writeback register, updated on the rising edge when !stall. It captures:
  - reg_we&&rd!=0
  - rd
  - result: pc+4 for jumps, else alu_result
  - mem_rr, funct3, addr[1:0]
- wb_data (combinational from the slot):
  - Load: dcache_dout shifted right by the byte offset, then sign-extended (lb/lh) or zero-extended (lbu/lhu).
  - Otherwise: the captured result.
- CSR register: on a non-stalled edge with csr_write, csr <= csr_imm ? {27'b0,rs1} : forwarded rs1 data. Held otherwise.
- Reset (asynchronous assert, synchronous release):
  - wb_we=0, wb_rd=0, the slot's result field=0, csr=0; wb_data therefore reads 0.
  - Mid-operation reset drops the in-flight writeback with no register write.
- Simultaneous stall and redirect: pc_select/bubble remain asserted until stall clears; the redirect is consumed once.
- Misaligned accesses are not trapped; the low address bits are ignored per size.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- With the macro: 32-bit cycle and instret counters are added, reset to 0.
  - cycle increments every non-stalled cycle.
  - instret increments per non-stalled, non-bubble retire.
  - A CSR instruction with rd!=0 addressing 12'hC00 or 12'hC02 writes the counter value to rd.
  - A 12-bit csr_addr input port is added.
- Without the macro: no counters; CSR reads return 0.

Test Plan:
- Reset low mid-run with wb_we=1 pending -> wb_we=0, csr=0, pc_select=0 immediately (asynchronous).
- add x3,x1,x2 followed by add x4,x3,x3 with x1=5, x2=7 -> second op forwards 12; wb_data=24, wb_rd=4.
- beq with ra=rb=9, pc=0x100, imm=0x20 -> pc_select=1, bubble=1, alu_result=0x120. With rb=8 -> both 0.
- sb with data 0xAB to address 0x1003 -> dcache_we=4'b1000, dcache_din[31:24]=0xAB, dcache_addr=0x1000.
- lh from offset 2 with dcache_dout=0x8001_1234 -> wb_data=0xFFFF8001; lhu -> 0x00008001.
- csrwi 0x51E,5 then stall held 3 cycles -> csr=5 after the first non-stalled edge; writeback slot unchanged during the stall.
